// File: rtl/adrv9009_rx_dec_ctrl.sv
// Control sequencer for the ADRV9009 RX half-band decimation chain: per-stage
// input strobes, runtime bypass reconfiguration with flush and re-prime settle.
module adrv9009_rx_dec_ctrl #(
    parameter int                    NUM_STAGES     = 3,
    parameter int                    SETTLE_SAMPLES = 32,
    parameter logic [NUM_STAGES-1:0] BYPASS_RST     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [NUM_STAGES-1:0] cfg_bypass,
    input  logic                  cfg_load,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_bypass,
    output logic                  stage_flush,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  cfg_ack,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_SETTLE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] phase_q, phase_d;
    logic [NUM_STAGES-1:0] mask_q, pend_q;
    logic [NUM_STAGES-1:0] s_in, s_out;
    logic [7:0]            cnt_q;
    logic                  from_flush_q;
    logic                  ack_q;
    logic                  settle_done;

    assign settle_done = (state_q == ST_SETTLE) && in_valid && (cnt_q == SETTLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (cfg_load) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_d = ST_RUN;
            default:   state_d = ST_SETTLE;
        endcase
    end

    // Strobe ripples through the chain; each active stage passes every other input.
    always_comb begin
        logic strobe;
        strobe  = in_valid;
        s_in    = '0;
        s_out   = '0;
        phase_d = phase_q;
        for (int k = 0; k < NUM_STAGES; k++) begin
            s_in[k] = strobe;
            if (mask_q[k]) begin
                s_out[k]   = strobe;
                phase_d[k] = 1'b0;
            end else begin
                s_out[k]   = strobe & phase_q[k];
                phase_d[k] = phase_q[k] ^ strobe;
            end
            strobe = s_out[k];
        end
        if (state_q == ST_FLUSH) phase_d = '0;
    end

    // Input-derived outputs are also gated by reset so they read zero while it is held.
    always_comb begin
        stage_en     = s_in & {NUM_STAGES{(state_q != ST_FLUSH) && reset}};
        out_valid    = s_out[NUM_STAGES-1] && (state_q == ST_RUN);
        stage_flush  = (state_q == ST_FLUSH);
        busy         = (state_q != ST_RUN);
        cfg_err      = cfg_load && (state_q != ST_RUN) && reset;
        cfg_ack      = ack_q;
        stage_bypass = mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q      <= '0;
            mask_q       <= BYPASS_RST;
            pend_q       <= BYPASS_RST;
            cnt_q        <= '0;
            from_flush_q <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ack_q   <= settle_done && from_flush_q;
            case (state_q)
                ST_RUN: begin
                    if (cfg_load) pend_q <= cfg_bypass;
                end
                ST_FLUSH: begin
                    mask_q       <= pend_q;
                    cnt_q        <= '0;
                    from_flush_q <= 1'b1;
                end
                ST_SETTLE: begin
                    if (in_valid) cnt_q <= cnt_q + 8'd1;
                    if (settle_done) from_flush_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adrv9009_rx_dec_ctrl.sv
// Directed bench for adrv9009_rx_dec_ctrl: vector table for steady-state RUN
// patterns plus hand sequences for reset, reconfiguration and settle.
module tb_adrv9009_rx_dec_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] cfg_bypass = 3'b000;
    logic       cfg_load = 1'b0;
    logic [2:0] stage_en;
    logic [2:0] stage_bypass;
    logic       stage_flush;
    logic       out_valid;
    logic       busy;
    logic       cfg_ack;
    logic       cfg_err;

    int nvec = 0;
    int nfail = 0;

    typedef struct {
        logic       iv;
        logic [2:0] en;
        logic       ov;
        logic       ack;
        logic       busy;
        logic [2:0] byp;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    adrv9009_rx_dec_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .cfg_bypass   (cfg_bypass),
        .cfg_load     (cfg_load),
        .stage_en     (stage_en),
        .stage_bypass (stage_bypass),
        .stage_flush  (stage_flush),
        .out_valid    (out_valid),
        .busy         (busy),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic cycle(input logic iv, input logic ld, input logic [2:0] byp);
        @(negedge clk);
        in_valid   = iv;
        cfg_load   = ld;
        cfg_bypass = byp;
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " stage_en"},     32'(stage_en),     32'h0);
        chk({tag, " out_valid"},    32'(out_valid),    32'h0);
        chk({tag, " stage_flush"},  32'(stage_flush),  32'h0);
        chk({tag, " cfg_ack"},      32'(cfg_ack),      32'h0);
        chk({tag, " cfg_err"},      32'(cfg_err),      32'h0);
        chk({tag, " busy"},         32'(busy),         32'h1);
        chk({tag, " stage_bypass"}, 32'(stage_bypass), 32'h0);
    endtask

    // Full-decimation chain from reset: /2, /4, /8 strobes, RUN after 32 samples.
    task automatic run_after_reset(input string tag);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 3'b000);
            chk($sformatf("%s[%0d] stage_en", tag, i), 32'(stage_en),
                32'({(i % 4) == 3, (i % 2) == 1, 1'b1}));
            chk($sformatf("%s[%0d] out_valid", tag, i), 32'(out_valid),
                32'((i >= 32) && ((i % 8) == 7)));
            chk($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(i < 32));
            chk($sformatf("%s[%0d] cfg_ack", tag, i), 32'(cfg_ack), 32'h0);
            chk($sformatf("%s[%0d] stage_flush", tag, i), 32'(stage_flush), 32'h0);
        end
    endtask

    task automatic reconfig(input logic [2:0] mask, input logic [2:0] old_mask);
        cycle(1'b0, 1'b1, mask);
        chk("rcfg load busy", 32'(busy), 32'h0);
        chk("rcfg load flush", 32'(stage_flush), 32'h0);
        chk("rcfg load err", 32'(cfg_err), 32'h0);
        cycle(1'b0, 1'b0, 3'b000);
        chk("rcfg flush pulse", 32'(stage_flush), 32'h1);
        chk("rcfg flush bypass", 32'(stage_bypass), 32'(old_mask));
        chk("rcfg flush busy", 32'(busy), 32'h1);
        for (int j = 0; j < 32; j++) begin
            cycle(1'b1, 1'b0, 3'b000);
            chk($sformatf("rcfg settle[%0d] busy", j), 32'(busy), 32'h1);
            chk($sformatf("rcfg settle[%0d] out_valid", j), 32'(out_valid), 32'h0);
            chk($sformatf("rcfg settle[%0d] bypass", j), 32'(stage_bypass), 32'(mask));
            chk($sformatf("rcfg settle[%0d] flush", j), 32'(stage_flush), 32'h0);
            chk($sformatf("rcfg settle[%0d] ack", j), 32'(cfg_ack), 32'h0);
        end
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            cycle(tbl[r].iv, 1'b0, 3'b000);
            chk($sformatf("row%0d stage_en", r), 32'(stage_en), 32'(tbl[r].en));
            chk($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
            chk($sformatf("row%0d cfg_ack", r), 32'(cfg_ack), 32'(tbl[r].ack));
            chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
            chk($sformatf("row%0d bypass", r), 32'(stage_bypass), 32'(tbl[r].byp));
        end
    endtask

    initial begin
        // Mask 011: only stage 2 decimates; output on 2nd and 4th valid samples.
        tbl[0]  = '{iv:1'b1, en:3'b111, ov:1'b0, ack:1'b1, busy:1'b0, byp:3'b011};
        tbl[1]  = '{iv:1'b0, en:3'b000, ov:1'b0, ack:1'b0, busy:1'b0, byp:3'b011};
        tbl[2]  = '{iv:1'b1, en:3'b111, ov:1'b1, ack:1'b0, busy:1'b0, byp:3'b011};
        tbl[3]  = '{iv:1'b1, en:3'b111, ov:1'b0, ack:1'b0, busy:1'b0, byp:3'b011};
        tbl[4]  = '{iv:1'b0, en:3'b000, ov:1'b0, ack:1'b0, busy:1'b0, byp:3'b011};
        tbl[5]  = '{iv:1'b1, en:3'b111, ov:1'b1, ack:1'b0, busy:1'b0, byp:3'b011};
        // Mask 111: everything bypassed, out_valid follows in_valid.
        tbl[6]  = '{iv:1'b1, en:3'b111, ov:1'b1, ack:1'b1, busy:1'b0, byp:3'b111};
        tbl[7]  = '{iv:1'b1, en:3'b111, ov:1'b1, ack:1'b0, busy:1'b0, byp:3'b111};
        tbl[8]  = '{iv:1'b0, en:3'b000, ov:1'b0, ack:1'b0, busy:1'b0, byp:3'b111};
        tbl[9]  = '{iv:1'b1, en:3'b111, ov:1'b1, ack:1'b0, busy:1'b0, byp:3'b111};
        tbl[10] = '{iv:1'b0, en:3'b000, ov:1'b0, ack:1'b0, busy:1'b0, byp:3'b111};
        tbl[11] = '{iv:1'b1, en:3'b111, ov:1'b1, ack:1'b0, busy:1'b0, byp:3'b111};

        // Reset held with live inputs: outputs still at reset values.
        in_valid = 1'b1;
        cfg_load = 1'b1;
        #12;
        chk_reset_outputs("reset");
        in_valid = 1'b0;
        cfg_load = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_after_reset("boot");

        // Reconfigure to 101 with rejected loads in FLUSH and SETTLE.
        cycle(1'b0, 1'b1, 3'b101);
        chk("c0 err", 32'(cfg_err), 32'h0);
        chk("c0 flush", 32'(stage_flush), 32'h0);
        chk("c0 bypass", 32'(stage_bypass), 32'h0);
        cycle(1'b1, 1'b1, 3'b111);
        chk("c1 flush", 32'(stage_flush), 32'h1);
        chk("c1 err", 32'(cfg_err), 32'h1);
        chk("c1 stage_en", 32'(stage_en), 32'h0);
        chk("c1 bypass", 32'(stage_bypass), 32'h0);
        chk("c1 busy", 32'(busy), 32'h1);
        for (int j = 0; j < 36; j++) begin
            cycle(1'b1, j == 5, 3'b010);
            chk($sformatf("m101[%0d] bypass", j), 32'(stage_bypass), 32'h5);
            chk($sformatf("m101[%0d] flush", j), 32'(stage_flush), 32'h0);
            chk($sformatf("m101[%0d] stage_en", j), 32'(stage_en),
                32'({(j % 2) == 1, 1'b1, 1'b1}));
            chk($sformatf("m101[%0d] out_valid", j), 32'(out_valid),
                32'((j >= 32) && ((j % 2) == 1)));
            chk($sformatf("m101[%0d] busy", j), 32'(busy), 32'(j < 32));
            chk($sformatf("m101[%0d] cfg_ack", j), 32'(cfg_ack), 32'(j == 32));
            chk($sformatf("m101[%0d] cfg_err", j), 32'(cfg_err), 32'(j == 5));
        end

        reconfig(3'b011, 3'b101);
        apply_rows(0, 5);
        reconfig(3'b111, 3'b011);
        apply_rows(6, 11);

        // Reconfigure to 110, then reset 5 samples into SETTLE.
        cycle(1'b0, 1'b1, 3'b110);
        cycle(1'b0, 1'b0, 3'b000);
        chk("r110 flush", 32'(stage_flush), 32'h1);
        for (int j = 0; j < 5; j++) begin
            cycle(1'b1, 1'b0, 3'b000);
            chk($sformatf("r110[%0d] bypass", j), 32'(stage_bypass), 32'h6);
            chk($sformatf("r110[%0d] busy", j), 32'(busy), 32'h1);
        end
        #1;
        cfg_load = 1'b1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        in_valid = 1'b0;
        cfg_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_after_reset("post");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/adrv9009_rx_dec_ctrl.md
Name: adrv9009_rx_dec_ctrl

Overview:
Sequencer for the ADRV9009 receive half-band decimation chain (RHB stages in series, each decimate-by-2 or bypass). Generates per-stage input-valid strobes from the front-end sample valid. Manages runtime bypass reconfiguration: latch, flush stage pipelines, then suppress output until the filters have re-primed. Sits beside the datapath stages and drives only their control inputs; sample data does not pass through this block.

Parameters:
NUM_STAGES, 3, number of half-band stages in the chain (stage 0 is nearest the ADC)
SETTLE_SAMPLES, 32, front-end input samples counted after a flush before output is re-enabled (1..255)
BYPASS_RST, 3'b000, active bypass mask loaded at reset

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
in_valid  input  1  front-end sample strobe, one sample per asserted cycle
cfg_bypass  input  NUM_STAGES  requested bypass mask; bit k=1 bypasses stage k
cfg_load  input  1  single-cycle request to apply cfg_bypass
stage_en  output  NUM_STAGES  input-valid strobe to each stage
stage_bypass  output  NUM_STAGES  active bypass mask driven to the stages
stage_flush  output  1  synchronous clear pulse to all stage pipelines
out_valid  output  1  valid strobe for the chain output
busy  output  1  high in FLUSH or SETTLE
cfg_ack  output  1  one-cycle pulse when a requested configuration is live
cfg_err  output  1  one-cycle pulse when cfg_load is rejected

Behaviour:
- Reset (reset=0, async): state=SETTLE; settle counter=0; all phase bits=0; active mask=BYPASS_RST. Outputs: stage_en=0, out_valid=0, stage_flush=0, cfg_ack=0, cfg_err=0, busy=1, stage_bypass=BYPASS_RST.
- FSM states: RUN, FLUSH, SETTLE.
  - RUN + cfg_load: latch cfg_bypass; next=FLUSH.
  - FLUSH: lasts exactly 1 cycle. stage_flush=1; all phase bits cleared; active mask<=latched mask (visible on stage_bypass in the following cycle); counter cleared; next=SETTLE.
  - SETTLE: counter increments on each in_valid. When in_valid is high with counter==SETTLE_SAMPLES-1, next=RUN.
    - cfg_ack pulses on the cycle RUN is entered, only if SETTLE was entered from FLUSH. No pulse on the exit from the reset settle.
- cfg_load in FLUSH or SETTLE: ignored; cfg_err=1 for that cycle; active and pending configuration unchanged.
- Strobe chain (combinational from in_valid and registered phase bits, zero latency). Define s_in[0]=in_valid and s_in[k]=s_out[k-1].
  - If stage k is bypassed: s_out[k]=s_in[k]; phase[k] held at 0.
  - Otherwise: s_out[k]=s_in[k] & phase[k]; phase[k] toggles on each s_in[k].
  - stage_en[k]=s_in[k] & (state!=FLUSH).
  - out_valid=s_out[NUM_STAGES-1] & (state==RUN).
  - The chain runs during SETTLE so the filters prime; only out_valid is gated.
  - Phase bits do not advance in FLUSH.
- Decimation ratio = 2^(number of cleared mask bits). All bits bypassed gives out_valid==in_valid in RUN.
- in_valid during FLUSH: sample dropped; no stage_en, no phase or counter change.
- cfg_load and in_valid in the same RUN cycle: the strobe is processed with the old mask; FLUSH follows.
- Reset asserted mid-FLUSH or mid-SETTLE: immediate return to reset values. Any pending mask is discarded and BYPASS_RST is restored.
- busy=(state!=RUN).

Test Plan:
- Reset release, BYPASS_RST=000, SETTLE_SAMPLES=32, in_valid continuous -> busy falls after 32 in_valid cycles. First out_valid appears at cycle 32+k with period 8 (k being the phase alignment of stage 2). stage_en[0] is 1 every cycle, stage_en[1] every 2nd cycle, stage_en[2] every 4th. No cfg_ack.
- In RUN, cfg_load with cfg_bypass=101 -> stage_flush=1 for exactly one cycle. stage_bypass=101 from the next cycle. out_valid low for 32 in_valid strobes. cfg_ack pulse on entering RUN. out_valid period then 2.
- cfg_load pulsed during SETTLE and again during FLUSH -> cfg_err pulse each time; stage_bypass unchanged; no extra flush.
- in_valid pattern 1,0,1,1,0,1 with mask 011 -> stage_en[2]=in_valid. out_valid alternates on stage-2 inputs only: the 2nd, 4th, ... valid samples.
- Assert reset 5 cycles into SETTLE after a reconfig to 110 -> outputs return to reset values asynchronously and stage_bypass=000. After release, busy for 32 samples and no cfg_ack.
- Mask 111 in RUN -> out_valid == in_valid, stage_en all equal to in_valid, phase bits remain 0.
